// File: rtl/serv_state_w.sv
// serv_state_w
// ------------
// Per-instruction sequencer for the bit-serial RISC-V core, parametrised
// for a datapath that moves W bits per cycle (W = 1, 2 or 4). A 32-bit
// operand pass takes 32/W enabled cycles.
//
// Instructions run in one of two flows:
//   - Single-stage ops: one RUN pass.
//   - Two-stage ops (slt, mem, branch, shift, optional mdu):
//       1. An INIT pass with o_init high.
//       2. A wait for the external unit (bus, shifter, MDU).
//       3. A RUN pass.
//
// Also tracks interrupt and misalignment traps (WITH_CSR) and an optional
// multiply/divide handshake (WITH_MDU).
//
// Parameters
//   W         bits per cycle: 1, 2 or 4
//   WITH_CSR  1 enables trap / IRQ / misalignment tracking
//   WITH_MDU  1 enables the MDU stage-two handshake
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//
//   Event / status inputs:
//     i_new_irq, i_ibus_ack, i_dbus_ack, i_rf_ready, i_take_branch,
//     i_ctrl_misalign, i_mem_misalign, i_alu_sh_done, i_mdu_ready
//
//   Decoded instruction class:
//     i_branch_op, i_mem_op, i_shift_op, i_slt_op, i_e_op, i_rd_op,
//     i_mdu_op
//
//   Registered state:
//     o_init, o_cnt_en, o_cnt_done, o_ctrl_jump, o_pending_irq
//
//   Bit-position strobes:
//     o_cnt0..o_cnt3, o_cnt7, o_cnt0to3, o_cnt12to31, o_alu_shamt_en
//
//   Control outputs:
//     o_ctrl_pc_en, o_ctrl_trap, o_trap_taken, o_rf_rreq, o_rf_wreq,
//     o_rf_rd_en, o_dbus_cyc, o_bufreg_hold, o_mdu_valid
//
//   o_mem_bytecnt          byte index of the current slice (cnt[4:3])

module serv_state_w #(
  parameter int W        = 1,
  parameter int WITH_CSR = 1,
  parameter int WITH_MDU = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_new_irq,
  input  logic       i_ibus_ack,
  input  logic       i_dbus_ack,
  input  logic       i_rf_ready,
  input  logic       i_take_branch,
  input  logic       i_ctrl_misalign,
  input  logic       i_mem_misalign,
  input  logic       i_alu_sh_done,
  input  logic       i_branch_op,
  input  logic       i_mem_op,
  input  logic       i_shift_op,
  input  logic       i_slt_op,
  input  logic       i_e_op,
  input  logic       i_rd_op,
  input  logic       i_mdu_op,
  input  logic       i_mdu_ready,
  output logic       o_init,
  output logic       o_cnt_en,
  output logic       o_cnt_done,
  output logic       o_ctrl_jump,
  output logic       o_pending_irq,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_cnt2,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_alu_shamt_en,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_trap,
  output logic       o_trap_taken,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  output logic       o_rf_rd_en,
  output logic       o_dbus_cyc,
  output logic       o_bufreg_hold,
  output logic       o_mdu_valid,
  output logic [1:0] o_mem_bytecnt
);

  localparam bit MDU_EN = (WITH_MDU != 0);

  // Upper counter bits: cnt = o_cnt[4:2], one step per 4 bits of the word.
  logic [2:0] cnt;

  // Which of the four bits inside the current 4-bit group the slice covers.
  logic [3:0] grp_sel;

  // Current slice is the last one in its 4-bit group.
  logic       ph_last;

  // The next enabled slice holds bit 31.
  logic       done_nxt_pos;

  logic       stage_two_pending;
  logic       stage_two_req;
  logic       trap_pending;
  logic       two_stage_op;

  // Phase within a 4-bit group. With W = 4 every slice is a whole group,
  // so no phase register exists.
  if (W == 4) begin : g_ph_none
    assign grp_sel      = 4'b1111;
    assign ph_last      = 1'b1;
    assign done_nxt_pos = (cnt == 3'd6);
  end else begin : g_ph
    localparam int PH_W = 4 / W;

    logic [PH_W-1:0] ph;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        ph <= PH_W'(1);
      end else if (o_cnt_en) begin
        ph <= {ph[PH_W-2:0], ph[PH_W-1]};
      end
    end

    assign ph_last = ph[PH_W-1];

    // Penultimate phase of group 7: the following slice is bit 31.
    assign done_nxt_pos = (cnt == 3'd7) & ph[PH_W-2];

    for (genvar k = 0; k < 4; k++) begin : g_sel
      assign grp_sel[k] = ph[k / W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= 3'd0;
    end else if (o_cnt_en & ph_last) begin
      // Wraps 7 -> 0, leaving the counter at zero after every pass.
      cnt <= cnt + 3'd1;
    end
  end

  // Bit-position strobes.
  assign o_cnt0to3      = (cnt == 3'd0);
  assign o_cnt12to31    = cnt[2] | (cnt[1:0] == 2'b11);
  assign o_cnt0         = (cnt == 3'd0) & grp_sel[0];
  assign o_cnt1         = (cnt == 3'd0) & grp_sel[1];
  assign o_cnt2         = (cnt == 3'd0) & grp_sel[2];
  assign o_cnt3         = (cnt == 3'd0) & grp_sel[3];
  assign o_cnt7         = (cnt == 3'd1) & grp_sel[3];
  assign o_mem_bytecnt  = cnt[2:1];

  // Shift amount is bits 0..4: all of group 0 plus the slice with bit 4.
  assign o_alu_shamt_en = o_init & ((cnt == 3'd0) | ((cnt == 3'd1) & grp_sel[0]));

  assign two_stage_op = i_slt_op | i_mem_op | i_branch_op | i_shift_op |
                        (MDU_EN & i_mdu_op);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_en          <= 1'b0;
      o_cnt_done        <= 1'b0;
      o_init            <= 1'b0;
      o_ctrl_jump       <= 1'b0;
      stage_two_pending <= 1'b0;
      stage_two_req     <= 1'b0;
    end else begin
      // Done has priority so a pass ends even if ready is still asserted.
      if (o_cnt_done) begin
        o_cnt_en <= 1'b0;
      end else if (i_rf_ready) begin
        o_cnt_en <= 1'b1;
      end

      o_cnt_done <= o_cnt_en & done_nxt_pos;

      // A ready that arrives while stage two is pending starts the RUN
      // pass, so o_init keeps its value. A pending IRQ suppresses INIT so
      // the trap is taken without a stage-two detour.
      if (o_cnt_done) begin
        o_init <= 1'b0;
      end else if (i_rf_ready & ~stage_two_pending) begin
        o_init <= two_stage_op & ~o_pending_irq;
      end

      if (o_cnt_en) begin
        stage_two_pending <= o_init;
      end

      stage_two_req <= o_cnt_done & o_init;

      if (o_cnt_done) begin
        o_ctrl_jump <= o_init & i_take_branch;
      end
    end
  end

  if (WITH_CSR != 0) begin : g_csr
    logic irq_sync;
    logic misalign_sync;
    logic pending_irq;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        irq_sync      <= 1'b0;
        misalign_sync <= 1'b0;
        pending_irq   <= 1'b0;
      end else begin
        // New IRQ wins over the fetch ack that would clear it.
        if (i_new_irq) begin
          irq_sync <= 1'b1;
        end else if (i_ibus_ack) begin
          irq_sync <= 1'b0;
        end

        // Captures the value from before any same-cycle new IRQ.
        if (i_ibus_ack) begin
          pending_irq <= irq_sync;
        end

        if (i_ibus_ack) begin
          misalign_sync <= 1'b0;
        end else if (stage_two_req) begin
          misalign_sync <= trap_pending;
        end
      end
    end

    assign o_pending_irq = pending_irq;
    assign trap_pending  = (o_ctrl_jump & i_ctrl_misalign) | i_mem_misalign;
    assign o_ctrl_trap   = i_e_op | pending_irq | misalign_sync;
    assign o_trap_taken  = i_ibus_ack & o_ctrl_trap;
  end else begin : g_no_csr
    assign o_pending_irq = 1'b0;
    assign trap_pending  = 1'b0;
    assign o_ctrl_trap   = 1'b0;
    assign o_trap_taken  = 1'b0;
  end

  // A misaligned stage two reads the trap vector instead of writing rd.
  assign o_rf_rreq = i_ibus_ack | (stage_two_req & trap_pending);

  assign o_rf_wreq = ~trap_pending &
                     ((i_shift_op & i_alu_sh_done & stage_two_pending) |
                      (i_mem_op & i_dbus_ack) |
                      (stage_two_req & (i_slt_op | i_branch_op)) |
                      (MDU_EN & i_mdu_op & i_mdu_ready & stage_two_pending));

  assign o_mdu_valid   = MDU_EN & i_mdu_op & stage_two_pending & ~o_cnt_en;
  assign o_dbus_cyc    = ~o_cnt_en & stage_two_pending & i_mem_op & ~i_mem_misalign;
  assign o_bufreg_hold = ~o_cnt_en & (stage_two_req | ~i_shift_op);
  assign o_ctrl_pc_en  = o_cnt_en & ~o_init;
  assign o_rf_rd_en    = i_rd_op & o_cnt_en & ~o_init;

endmodule
